// File: rtl/regfile_mp_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned REGFILE_WIDTH = 32;
  localparam int unsigned REGFILE_DEPTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_array.sv
// Register storage: one synchronous write port, two asynchronous read ports.
// Contents are never reset; out-of-range read addresses return zero.
module regfile_array
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH = REGFILE_WIDTH,
  parameter int unsigned DEPTH = REGFILE_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // The owner only asserts we_i with an in-range address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (32'(raddr1_i) < DEPTH) ? mem_q[raddr1_i] : '0;
  assign rdata2_o = (32'(raddr2_i) < DEPTH) ? mem_q[raddr2_i] : '0;

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with a zero register, optional write
// forwarding and a sequential clear sweep that also runs out of reset.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH    = REGFILE_WIDTH,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             clear_in,
  input  logic             wen_in,
  input  logic [AW-1:0]    waddr_in,
  input  logic [WIDTH-1:0] wdata_in,
  output logic             wready_out,
  input  logic             ren1_in,
  input  logic [AW-1:0]    raddr1_in,
  input  logic             ren2_in,
  input  logic [AW-1:0]    raddr2_in,
  output logic [WIDTH-1:0] rdata1_out,
  output logic [WIDTH-1:0] rdata2_out,
  output logic             busy_out
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e           state_q;
  logic [AW-1:0]    clr_ptr_q;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [WIDTH-1:0] rdata2_q, rdata2_d;

  logic             busy_c;
  logic             wr_acc_c;
  logic             arr_we;
  logic [AW-1:0]    arr_waddr;
  logic [WIDTH-1:0] arr_wdata;
  logic [WIDTH-1:0] mem1, mem2;

  // Address names a real, writable/readable register (not the hard zero).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] read_val(
    input logic             busy,
    input logic             wacc,
    input logic [AW-1:0]    wa,
    input logic [WIDTH-1:0] wd,
    input logic [AW-1:0]    ra,
    input logic [WIDTH-1:0] stored
  );
    if (busy || !addr_ok(ra)) begin
      return '0;
    end
    if (BYPASS && wacc && (wa == ra)) begin
      return wd;
    end
    return stored;
  endfunction

  assign busy_c     = (state_q == CLEAR);
  assign wr_acc_c   = !busy_c && wen_in && addr_ok(waddr_in);
  assign busy_out   = busy_c;
  assign wready_out = !busy_c;
  assign rdata1_out = rdata1_q;
  assign rdata2_out = rdata2_q;

  regfile_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk      (clk),
    .we_i     (arr_we),
    .waddr_i  (arr_waddr),
    .wdata_i  (arr_wdata),
    .raddr1_i (raddr1_in),
    .raddr2_i (raddr2_in),
    .rdata1_o (mem1),
    .rdata2_o (mem2)
  );

  // Array write mux (sweep owns the port while busy) and read-data next values.
  always_comb begin
    arr_we    = wr_acc_c;
    arr_waddr = waddr_in;
    arr_wdata = wdata_in;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    if (busy_c) begin
      arr_we    = 1'b1;
      arr_waddr = clr_ptr_q;
      arr_wdata = '0;
    end
    if (ren1_in) begin
      rdata1_d = read_val(busy_c, wr_acc_c, waddr_in, wdata_in, raddr1_in, mem1);
    end
    if (ren2_in) begin
      rdata2_d = read_val(busy_c, wr_acc_c, waddr_in, wdata_in, raddr2_in, mem2);
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
    end else begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      case (state_q)
        IDLE: begin
          if (clear_in) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
          end
        end
        CLEAR: begin
          if (clr_ptr_q == LAST_ADDR) begin
            state_q <= IDLE;
          end else begin
            clr_ptr_q <= clr_ptr_q + AW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register in bits.
REQ-002 Parameter DEPTH, default 32: number of registers, 2 to 256, not required to be a power of two.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to a matching read.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port clear_in, input, 1 bit: request to re-zero the whole file.
REQ-009 Port wen_in, input, 1 bit: write enable.
REQ-010 Port waddr_in, input, AW bits: write address.
REQ-011 Port wdata_in, input, WIDTH bits: write data.
REQ-012 Port wready_out, output, 1 bit: write accepted this cycle when high; equals !busy_out.
REQ-013 Ports ren1_in and ren2_in, input, 1 bit each: read enables for ports 1 and 2.
REQ-014 Ports raddr1_in and raddr2_in, input, AW bits each: read addresses.
REQ-015 Ports rdata1_out and rdata2_out, output, WIDTH bits each: registered read data.
REQ-016 Port busy_out, output, 1 bit: high while the clear sweep runs.

Function
REQ-017 The FSM SHALL have two states: IDLE and CLEAR.
REQ-018 In CLEAR, each cycle SHALL write 0 to mem[clr_ptr] and increment clr_ptr.
REQ-019 When clr_ptr = DEPTH-1 in CLEAR, the FSM SHALL enter IDLE next cycle, so a sweep lasts exactly DEPTH cycles.
REQ-020 clear_in high in IDLE SHALL enter CLEAR with clr_ptr=0 on the next edge; clear_in in CLEAR SHALL be ignored (no restart).
REQ-021 busy_out SHALL be 1 exactly while state=CLEAR; wready_out SHALL be its inverse.
REQ-022 In IDLE, a write SHALL update mem[waddr_in] when wen_in=1 and waddr_in<DEPTH, and not (ZERO_REG=1 and waddr_in=0).
REQ-023 A write presented while busy_out=1 SHALL be dropped with no side effect.
REQ-024 A read SHALL have 1-cycle latency: when renN_in=1, rdataN_out takes the read value at the next rising edge.
REQ-025 When renN_in=0, rdataN_out SHALL hold its value.
REQ-026 The read value SHALL be 0 when any of these holds: busy_out=1; raddr>=DEPTH; ZERO_REG=1 and raddr=0.
REQ-027 Otherwise, with BYPASS=1, an accepted write to the same address in the same cycle SHALL supply wdata_in; otherwise the read value SHALL be mem[raddr].
REQ-028 With BYPASS=0, a same-address read SHALL return the pre-write contents.
REQ-029 Both read ports SHALL be independent; identical addresses SHALL return identical data.

Reset
REQ-030 reset_in high SHALL immediately force state=CLEAR, clr_ptr=0, rdata1_out=0, rdata2_out=0 and busy_out=1, independent of clk.
REQ-031 Array contents SHALL NOT be reset asynchronously; they are zeroed by the sweep.
REQ-032 Assertion of reset_in mid-sweep or mid-write SHALL restart the sweep from 0 after deassertion.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, CLEAR) and the defaults for WIDTH and DEPTH.
REQ-034 The storage array with one write port and two asynchronous read ports SHALL be a sub-module named regfile_array; the FSM, bypass and output registers SHALL reside in regfile_mp.

Verification
REQ-035 Reset pulse, then idle: busy_out high for exactly 32 cycles after deassertion; afterwards reads of addresses 1..31 return 0.
REQ-036 Write 0xDEADBEEF to address 5, then read port 1 at address 5 on the next cycle: rdata1_out = 0xDEADBEEF one cycle later.
REQ-037 Same cycle: write 0x12345678 to address 7 and read both ports at address 7, with BYPASS=1: both outputs = 0x12345678; with BYPASS=0: both outputs = previous value.
REQ-038 Write 0xFFFFFFFF to address 0 with ZERO_REG=1, then read address 0: result 0. With DEPTH=24, write to address 30: ignored, and a read of address 30 returns 0.
REQ-039 Fill addresses 1..31, pulse clear_in, and write to address 3 during the sweep: write dropped (wready_out=0), and after 32 cycles all reads return 0.
REQ-040 Assert reset_in asynchronously at sweep cycle 10: outputs zero immediately, and busy_out stays high for 32 cycles after release.
